// File: rtl/fmul_sched_pkg.sv
// fmul_sched_pkg -- shared types and width helpers for the multiplier scheduler.
// Rev 1.0
`default_nettype none

package fmul_sched_pkg;

  localparam int FP_W     = 32;
  localparam int ID_MAX_W = 2;   // enough for up to 4 requesters

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/fmul_res_fifo.sv
// fmul_res_fifo -- 32-bit synchronous result FIFO with occupancy count.
// Rev 1.0
`default_nettype none

module fmul_res_fifo
  import fmul_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [FP_W-1:0]             push_data,
  input  logic                        pop,
  output logic [FP_W-1:0]             head,
  output logic                        empty,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [FP_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_pop_ok;

  assign w_pop_ok = pop && !empty;
  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;
  assign head     = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push)     r_wr <= r_wr + 1'b1;
      if (w_pop_ok) r_rd <= r_rd + 1'b1;
      case ({push, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fmul_sched.sv
// fmul_sched -- round-robin, credit-gated sharing of one pipelined FP multiplier.
// Rev 1.0
`default_nettype none

module fmul_sched
  import fmul_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int MUL_LATENCY = 5,
  parameter int RES_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [FP_W*NREQ-1:0] req_a,
  input  logic [FP_W*NREQ-1:0] req_b,
  output logic [FP_W-1:0]      mul_a,
  output logic [FP_W-1:0]      mul_b,
  output logic                 mul_issue,
  input  logic [FP_W-1:0]      mul_z,
  output logic [NREQ-1:0]      res_valid,
  input  logic [NREQ-1:0]      res_ready,
  output logic [FP_W*NREQ-1:0] res_z,
  output logic                 busy
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = cnt_width(RES_DEPTH);

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_issue_id;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_gnt_any;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  logic [NREQ-1:0] w_empty;
  logic [NREQ-1:0] w_full;
  logic [NREQ-1:0] w_live;
  logic [FP_W-1:0] w_sel_a;
  logic [FP_W-1:0] w_sel_b;
  logic [CW-1:0]   r_inflight [NREQ];
  logic [CW-1:0]   w_occ      [NREQ];
  tag_t            r_tag      [MUL_LATENCY];
  tag_t            w_tail;

  assign w_tail = r_tag[MUL_LATENCY-1];

  // Two passes give the wrapping upward search starting at the pointer.
  always_comb begin
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_valid[i] &&
                  (({1'b0, r_inflight[i]} + {1'b0, w_occ[i]}) < (CW+1)'(RES_DEPTH));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_any && (IDW'(i) >= r_ptr) && w_elig[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_any && (IDW'(i) < r_ptr) && w_elig[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_any && (w_gnt_id == IDW'(i))) begin
        w_gnt[i] = 1'b1;
        w_sel_a  = req_a[i*FP_W +: FP_W];
        w_sel_b  = req_b[i*FP_W +: FP_W];
      end
    end
  end

  assign req_ready = reset ? '0 : w_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_issue_id <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_issue  <= 1'b0;
      for (int s = 0; s < MUL_LATENCY; s++) r_tag[s] <= '0;
    end else begin
      mul_issue  <= w_gnt_any;
      mul_a      <= w_gnt_any ? w_sel_a : '0;
      mul_b      <= w_gnt_any ? w_sel_b : '0;
      r_issue_id <= w_gnt_id;
      if (w_gnt_any) begin
        r_ptr <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;
      end
      r_tag[0] <= '{valid: mul_issue, id: ID_MAX_W'(r_issue_id)};
      for (int s = 1; s < MUL_LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      logic w_inc;
      logic w_dec;

      // Credit is taken at the handshake edge so the op is counted before it reaches mul_a.
      assign w_inc     = w_gnt_any && !reset && (w_gnt_id == IDW'(i));
      assign w_dec     = w_tail.valid && (w_tail.id == ID_MAX_W'(i));
      assign w_push[i] = w_dec;
      assign w_pop[i]  = res_valid[i] && res_ready[i];
      assign res_valid[i] = !w_empty[i];
      assign w_live[i] = (r_inflight[i] != '0) || (w_occ[i] != '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_inflight[i] <= '0;
        end else if (w_inc && !w_dec) begin
          r_inflight[i] <= r_inflight[i] + 1'b1;
        end else if (w_dec && !w_inc) begin
          r_inflight[i] <= r_inflight[i] - 1'b1;
        end
      end

      fmul_res_fifo #(
        .DEPTH (RES_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push[i]),
        .push_data (mul_z),
        .pop       (w_pop[i]),
        .head      (res_z[i*FP_W +: FP_W]),
        .empty     (w_empty[i]),
        .full      (w_full[i]),
        .count     (w_occ[i])
      );

      a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(w_push[i] && w_full[i]));
    end
  endgenerate

  assign busy = (|w_live) || mul_issue;

endmodule

`default_nettype wire
